ram_nr1w_dbg: RTL

//  Parametrised successor to the fixed 2-read/1-write HLS scratch RAM. Provides
//  NUM_RD read ports, one functional write port with configurable write delay,
//  and a debug read/write port for testbench memory load and check.
//  New features: ren-gated read holding, optional write-to-read bypass and a

---
 rtl/mem_pkg.sv | 17 +
 rtl/delay.sv | 21 ++
 rtl/ram_nr1w_dbg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the scratch RAM family: clear-sweep FSM states and an
// elaboration-time clog2 used for address-width sanity checks.
package mem_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/delay.sv
// One register stage with async active-low reset to zero; chained by callers
// to build write-delay and read-latency pipelines. Latency 1, no backpressure.
module delay #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] dat_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dat_q <= '0;
      else      dat_q <= d;
   end

   assign q = dat_q;

endmodule

// File: rtl/ram_nr1w_dbg.sv
// NUM_RD-read / 1-write scratch RAM with debug port, delayed write path and post-reset clear.
// Read latency RD_LAT, write commit after WR_DELAY stages; no backpressure, busy only during clear.
module ram_nr1w_dbg
   import mem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_W     = 5,
   parameter int NUM_RD     = 2,
   parameter int WR_DELAY   = 1,
   parameter int RD_LAT     = 1,
   parameter int BYPASS     = 0,
   parameter int CLEAR_INIT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   input  logic [NUM_RD-1:0]        ren,
   output logic [NUM_RD*WIDTH-1:0]  rdata,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     wen,
   input  logic [ADDR_W-1:0]        debug_addr,
   output logic [WIDTH-1:0]         debug_data,
   input  logic [ADDR_W-1:0]        debug_write_addr,
   input  logic [WIDTH-1:0]         debug_write_data,
   input  logic                     debug_write_en,
   output logic                     busy
);

   localparam int                IDX_W    = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
   localparam clr_state_e        ST_RST   = (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;

   if (ADDR_W < clog2(DEPTH)) begin : g_chk_addr_w
      $error("ram_nr1w_dbg: ADDR_W too narrow for DEPTH");
   end
   if (NUM_RD < 1) begin : g_chk_num_rd
      $error("ram_nr1w_dbg: NUM_RD must be >= 1");
   end
   if (RD_LAT < 1) begin : g_chk_rd_lat
      $error("ram_nr1w_dbg: RD_LAT must be >= 1");
   end

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < DEPTH_A;
   endfunction

   // ---------------- clear sweep ----------------
   clr_state_e       state_q, state_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             ready;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + IDX_W'(1);
         if (clr_cnt_q == LAST_IDX) begin
            state_d   = ST_READY;
            clr_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RST;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign ready = (state_q == ST_READY);
   assign busy  = (CLEAR_INIT != 0) ? ~ready : 1'b0;

   // ---------------- write path ----------------
   // Writes are dropped at entry while clearing; once READY the FSM only leaves via reset,
   // which also flushes the stages, so nothing accepted can commit during a sweep.
   logic              wp_vld  [WR_DELAY+1];
   logic [ADDR_W-1:0] wp_addr [WR_DELAY+1];
   logic [WIDTH-1:0]  wp_dat  [WR_DELAY+1];

   assign wp_vld[0]  = wen & ready;
   assign wp_addr[0] = waddr;
   assign wp_dat[0]  = wdata;

   for (genvar s = 0; s < WR_DELAY; s++) begin : g_wdly
      delay #(.W(1))      u_vld  (.clk(clk), .rst(rst), .d(wp_vld[s]),  .q(wp_vld[s+1]));
      delay #(.W(ADDR_W)) u_addr (.clk(clk), .rst(rst), .d(wp_addr[s]), .q(wp_addr[s+1]));
      delay #(.W(WIDTH))  u_dat  (.clk(clk), .rst(rst), .d(wp_dat[s]),  .q(wp_dat[s+1]));
   end

   logic              cm_vld;
   logic [ADDR_W-1:0] cm_addr;
   logic [WIDTH-1:0]  cm_dat;
   logic              dw_vld;

   assign cm_addr = wp_addr[WR_DELAY];
   assign cm_dat  = wp_dat[WR_DELAY];
   assign cm_vld  = wp_vld[WR_DELAY] & in_range(cm_addr);
   assign dw_vld  = debug_write_en & ready & in_range(debug_write_addr);

   // ---------------- storage ----------------
   logic [WIDTH-1:0] mem [DEPTH];

   // Debug write is issued last so it overrides a same-address functional commit.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem[clr_cnt_q] <= '0;
      end else begin
         if (cm_vld) mem[cm_addr[IDX_W-1:0]] <= cm_dat;
         if (dw_vld) mem[debug_write_addr[IDX_W-1:0]] <= debug_write_data;
      end
   end

   assign debug_data = in_range(debug_addr) ? mem[debug_addr[IDX_W-1:0]] : '0;

   // ---------------- read ports ----------------
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [WIDTH-1:0]  rv;
      logic              rp_vld [RD_LAT];
      logic [WIDTH-1:0]  rp_dat [RD_LAT];
      logic [WIDTH-1:0]  rdata_q, rdata_d;

      assign ra = raddr[i*ADDR_W +: ADDR_W];

      always_comb begin
         rv = '0;
         if (ready && in_range(ra)) begin
            rv = mem[ra[IDX_W-1:0]];
            if (BYPASS != 0) begin
               if (dw_vld && (debug_write_addr == ra)) rv = debug_write_data;
               else if (cm_vld && (cm_addr == ra))     rv = cm_dat;
            end
         end
      end

      assign rp_vld[0] = ren[i];
      assign rp_dat[0] = rv;

      for (genvar s = 0; s < RD_LAT - 1; s++) begin : g_rdly
         delay #(.W(1))     u_vld (.clk(clk), .rst(rst), .d(rp_vld[s]), .q(rp_vld[s+1]));
         delay #(.W(WIDTH)) u_dat (.clk(clk), .rst(rst), .d(rp_dat[s]), .q(rp_dat[s+1]));
      end

      // Final stage only loads when a sample exits, so idle cycles hold the last result.
      always_comb begin
         rdata_d = rdata_q;
         if (rp_vld[RD_LAT-1]) rdata_d = rp_dat[RD_LAT-1];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) rdata_q <= '0;
         else      rdata_q <= rdata_d;
      end

      assign rdata[i*WIDTH +: WIDTH] = rdata_q;
   end

endmodule
